execute_stage: RTL

//  RV32I execute stage. Consumes decoded instructions from decode and forwarded operands from forwarding_unit.

---
 rtl/cpu_pkg.sv | 98 +++++++++
 rtl/alu.sv | 46 ++++
 rtl/execute_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32I encodings, stage payload types and ALU op decode
package cpu_pkg;

  localparam int REGISTER_DEPTH = 32;

  typedef logic [31:0] RegisterValue;

  // Major opcodes
  localparam logic [6:0] OP_LOAD                 = 7'b0000011;
  localparam logic [6:0] OP_STORE                = 7'b0100011;
  localparam logic [6:0] OP_BRANCH               = 7'b1100011;
  localparam logic [6:0] OP_JAL                  = 7'b1101111;
  localparam logic [6:0] OP_JALR                 = 7'b1100111;
  localparam logic [6:0] OP_LUI                  = 7'b0110111;
  localparam logic [6:0] OP_AUIPC                = 7'b0010111;
  localparam logic [6:0] OP_ARITHMETIC_IMMEDIATE = 7'b0010011;
  localparam logic [6:0] OP_ARITHMETIC           = 7'b0110011;

  // Arithmetic funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 bit selecting SUB / SRA
  localparam int F7_ALT_BIT = 5;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } decoded_instruction_t;

  typedef struct packed {
    decoded_instruction_t decoded_instruction;
    RegisterValue         pc;
    RegisterValue         imm;
  } decode_to_execute_t;

  typedef struct packed {
    decoded_instruction_t decoded_instruction;
    RegisterValue         pc;
    RegisterValue         alu_result;
    RegisterValue         store_data;
  } execute_to_memory_t;

  // Opcodes that write rd; their result must read as zero when rd is x0
  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL) ||
           (opcode == OP_JALR) || (opcode == OP_LOAD) || (opcode == OP_ARITHMETIC) ||
           (opcode == OP_ARITHMETIC_IMMEDIATE);
  endfunction

  // SUB exists only in register form; SRA/SRAI share the funct7 alternate bit
  function automatic alu_op_t decode_alu_op(input logic [2:0] funct3, input logic alt,
                                            input logic is_register);
    case (funct3)
      F3_ADD_SUB: return (alt && is_register) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I ALU and branch comparator
module alu
  import cpu_pkg::*;
(
  input  alu_op_t      op,
  input  RegisterValue a,
  input  RegisterValue b,
  input  logic [2:0]   branch_funct3,
  output RegisterValue result,
  output logic         branch_cond
);

  // Arithmetic/logic result; shifts use only the low five bits of b
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << b[4:0];
      ALU_SLT:    result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'b0, a < b};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> b[4:0];
      ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

  // Branch condition on a (rs1) and b (rs2); reserved funct3 codes never branch
  always_comb begin
    branch_cond = 1'b0;
    case (branch_funct3)
      F3_BEQ:  branch_cond = (a == b);
      F3_BNE:  branch_cond = (a != b);
      F3_BLT:  branch_cond = ($signed(a) < $signed(b));
      F3_BGE:  branch_cond = ($signed(a) >= $signed(b));
      F3_BLTU: branch_cond = (a < b);
      F3_BGEU: branch_cond = (a >= b);
      default: branch_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage with load-use interlock and redirect squash
module execute_stage
  import cpu_pkg::*;
#(
  parameter int XLEN                  = 32,
  parameter bit ENABLE_LOAD_USE_STALL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  decode_to_execute_t axis_decode_to_execute_tdata,
  input  logic               axis_decode_to_execute_tvalid,
  output logic               axis_decode_to_execute_tready,
  input  logic [XLEN-1:0]    rs1_value,
  input  logic [XLEN-1:0]    rs2_value,
  output execute_to_memory_t axis_execute_to_memory_tdata,
  output logic               axis_execute_to_memory_tvalid,
  input  logic               axis_execute_to_memory_tready,
  output logic               branch_taken,
  output logic [XLEN-1:0]    branch_target
);

  decoded_instruction_t in_instr;
  decoded_instruction_t out_instr;
  execute_to_memory_t   out_data;
  execute_to_memory_t   next_out;
  logic                 out_valid;
  logic                 load_use;
  logic                 accept;

  alu_op_t              alu_op;
  RegisterValue         alu_a;
  RegisterValue         alu_b;
  RegisterValue         alu_result;
  logic                 branch_cond;
  logic                 use_alu;
  logic                 redirect;
  RegisterValue         redirect_target;

  assign in_instr  = axis_decode_to_execute_tdata.decoded_instruction;
  assign out_instr = out_data.decoded_instruction;

  // Hold a consumer of a load still sitting in the output register; it gets the data by forwarding later
  always_comb begin
    load_use = ENABLE_LOAD_USE_STALL && out_valid && (out_instr.opcode == OP_LOAD) &&
               (out_instr.rd != 5'd0) &&
               ((out_instr.rd == in_instr.rs1) || (out_instr.rd == in_instr.rs2));
  end

  assign axis_decode_to_execute_tready = (!out_valid || axis_execute_to_memory_tready) && !load_use;
  assign accept = axis_decode_to_execute_tvalid && axis_decode_to_execute_tready;

  // Operand and op selection per opcode; branches and unknown opcodes produce no result
  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rs1_value;
    alu_b   = axis_decode_to_execute_tdata.imm;
    use_alu = 1'b1;
    case (in_instr.opcode)
      OP_ARITHMETIC: begin
        alu_b  = rs2_value;
        alu_op = decode_alu_op(in_instr.funct3, in_instr.funct7[F7_ALT_BIT], 1'b1);
      end
      OP_ARITHMETIC_IMMEDIATE: begin
        alu_op = decode_alu_op(in_instr.funct3, in_instr.funct7[F7_ALT_BIT], 1'b0);
      end
      OP_LUI: begin
        alu_op = ALU_PASS_B;
      end
      OP_AUIPC: begin
        alu_a = axis_decode_to_execute_tdata.pc;
      end
      OP_JAL, OP_JALR: begin
        alu_a = axis_decode_to_execute_tdata.pc;
        alu_b = 32'd4;
      end
      OP_LOAD, OP_STORE: begin
        alu_op = ALU_ADD;
      end
      OP_BRANCH: begin
        alu_b   = rs2_value;
        use_alu = 1'b0;
      end
      default: begin
        use_alu = 1'b0;
      end
    endcase
  end

  alu u_alu (
    .op           (alu_op),
    .a            (alu_a),
    .b            (alu_b),
    .branch_funct3(in_instr.funct3),
    .result       (alu_result),
    .branch_cond  (branch_cond)
  );

  // Redirect decision and target; JALR clears bit 0, misalignment is left to fetch
  always_comb begin
    redirect        = 1'b0;
    redirect_target = axis_decode_to_execute_tdata.pc + axis_decode_to_execute_tdata.imm;
    case (in_instr.opcode)
      OP_BRANCH: redirect = branch_cond;
      OP_JAL:    redirect = 1'b1;
      OP_JALR: begin
        redirect        = 1'b1;
        redirect_target = (rs1_value + axis_decode_to_execute_tdata.imm) & ~32'd1;
      end
      default:   redirect = 1'b0;
    endcase
  end

  // Payload for the memory stage; writes to x0 read back as zero downstream
  always_comb begin
    next_out                     = '0;
    next_out.decoded_instruction = in_instr;
    next_out.pc                  = axis_decode_to_execute_tdata.pc;
    if (use_alu && !(writes_rd(in_instr.opcode) && (in_instr.rd == 5'd0))) begin
      next_out.alu_result = alu_result;
    end
    if (in_instr.opcode == OP_STORE) begin
      next_out.store_data = rs2_value;
    end
  end

  // Output register, one-cycle redirect pulse, and squash of the instruction behind a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      branch_taken <= 1'b0;
      if (accept && !branch_taken) begin
        out_valid     <= 1'b1;
        out_data      <= next_out;
        branch_taken  <= redirect;
        branch_target <= redirect_target;
      end else if (accept || axis_execute_to_memory_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign axis_execute_to_memory_tvalid = out_valid;
  assign axis_execute_to_memory_tdata  = out_data;

endmodule
